// File: rtl/r4_rt_otf_conv_if.sv
// Handshake and data bundle between the sqrt digit datapath, the on-the-fly root converter and the round/pack stage.
interface r4_rt_otf_conv_if #(
  parameter int RT_W = 26
);
  logic            flush_i;
  logic            start_valid_i;
  logic            start_ready_o;
  logic            dig_valid_i;
  logic            dig_ready_o;
  logic [4:0]      rt_dig_i;
  logic            rem_valid_i;
  logic            rem_ready_o;
  logic            rem_neg_i;
  logic            rem_zero_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [RT_W-1:0] rt_o;
  logic            inexact_o;
  logic            dig_err_o;

  modport slave (
    input  flush_i, start_valid_i, dig_valid_i, rt_dig_i,
    input  rem_valid_i, rem_neg_i, rem_zero_i, res_ready_i,
    output start_ready_o, dig_ready_o, rem_ready_o,
    output res_valid_o, rt_o, inexact_o, dig_err_o
  );

  modport master (
    output flush_i, start_valid_i, dig_valid_i, rt_dig_i,
    output rem_valid_i, rem_neg_i, rem_zero_i, res_ready_i,
    input  start_ready_o, dig_ready_o, rem_ready_o,
    input  res_valid_o, rt_o, inexact_o, dig_err_o
  );
endinterface

// File: rtl/r4_rt_otf_conv.sv
// On-the-fly radix-4 root assembly (Q and QM=Q-1) with final remainder sign correction.
// Optional macro R4_OTF_ONEHOT_CHK_EN: flags non-one-hot digits on dig_err_o and decodes them as zero.
module r4_rt_otf_conv #(
  parameter  int RT_W    = 26,
  localparam int NUM_DIG = RT_W / 2
) (
  input logic              clk,
  input logic              rst_n,
  r4_rt_otf_conv_if.slave  bus
);
  localparam int CNT_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  typedef enum logic [1:0] {IDLE, ITER, WREM, DONE} state_t;

  state_t            state, state_nxt;
  logic [RT_W-1:0]   q, qm, q_nxt, qm_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [RT_W-1:0]   rt;
  logic              inexact, res_valid, dig_err;
  logic              start_acc, dig_acc, rem_acc, res_acc;
  logic [4:0]        dsel;
  logic              dig_bad;

  assign bus.start_ready_o = (state == IDLE);
  assign bus.dig_ready_o   = (state == ITER);
  assign bus.rem_ready_o   = (state == WREM);
  assign bus.res_valid_o   = res_valid;
  assign bus.rt_o          = rt;
  assign bus.inexact_o     = inexact;
  assign bus.dig_err_o     = dig_err;

  // Normalise the incoming digit to a guaranteed one-hot select.
  always_comb begin
    dsel    = 5'b00100;
    dig_bad = 1'b0;
`ifdef R4_OTF_ONEHOT_CHK_EN
    if ($onehot(bus.rt_dig_i)) dsel = bus.rt_dig_i;
    else                       dig_bad = 1'b1;
`else
    if      (bus.rt_dig_i[4]) dsel = 5'b10000;
    else if (bus.rt_dig_i[3]) dsel = 5'b01000;
    else if (bus.rt_dig_i[2]) dsel = 5'b00100;
    else if (bus.rt_dig_i[1]) dsel = 5'b00010;
    else if (bus.rt_dig_i[0]) dsel = 5'b00001;
`endif
  end

  always_comb begin
    q_nxt  = {q[RT_W-3:0], 2'd0};
    qm_nxt = {qm[RT_W-3:0], 2'd3};
    case (dsel)
      5'b00001: begin q_nxt = {q[RT_W-3:0],  2'd2}; qm_nxt = {q[RT_W-3:0],  2'd1}; end
      5'b00010: begin q_nxt = {q[RT_W-3:0],  2'd1}; qm_nxt = {q[RT_W-3:0],  2'd0}; end
      5'b01000: begin q_nxt = {qm[RT_W-3:0], 2'd3}; qm_nxt = {qm[RT_W-3:0], 2'd2}; end
      5'b10000: begin q_nxt = {qm[RT_W-3:0], 2'd2}; qm_nxt = {qm[RT_W-3:0], 2'd1}; end
      default:  ;
    endcase
  end

  // Flush masks every handshake so it wins over simultaneous accepts.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    dig_acc   = 1'b0;
    rem_acc   = 1'b0;
    res_acc   = 1'b0;
    if (bus.flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start_valid_i) begin
          start_acc = 1'b1;
          state_nxt = ITER;
        end
        ITER: if (bus.dig_valid_i) begin
          dig_acc = 1'b1;
          if (cnt == CNT_W'(NUM_DIG - 1)) state_nxt = WREM;
        end
        WREM: if (bus.rem_valid_i) begin
          rem_acc   = 1'b1;
          state_nxt = DONE;
        end
        DONE: if (res_valid && bus.res_ready_i) begin
          res_acc   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      rt        <= '0;
      inexact   <= 1'b0;
      res_valid <= 1'b0;
      dig_err   <= 1'b0;
    end else if (bus.flush_i) begin
      cnt       <= '0;
      res_valid <= 1'b0;
    end else begin
      if (start_acc) begin
        q       <= '0;
        qm      <= '1;
        cnt     <= '0;
        dig_err <= 1'b0;
      end
      if (dig_acc) begin
        q   <= q_nxt;
        qm  <= qm_nxt;
        cnt <= cnt + CNT_W'(1);
        if (dig_bad) dig_err <= 1'b1;
      end
      if (rem_acc) begin
        rt        <= bus.rem_neg_i ? qm : q;
        inexact   <= bus.rem_neg_i | ~bus.rem_zero_i;
        res_valid <= 1'b1;
      end
      if (res_acc) res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_r4_rt_otf_conv.sv
// Randomised self-checking bench for r4_rt_otf_conv; root expectations come from the signed-digit value sum(d_i*4^k).
module tb_r4_rt_otf_conv;
  localparam int RT_W    = 8;
  localparam int NUM_DIG = RT_W / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r4_rt_otf_conv_if #(.RT_W(RT_W)) bus ();
  r4_rt_otf_conv #(.RT_W(RT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

`ifdef R4_OTF_ONEHOT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef int         dig_arr_t  [NUM_DIG];
  typedef logic [4:0] code_arr_t [NUM_DIG];

  function automatic logic [4:0] enc(input int d);
    case (d)
      2:       return 5'b00001;
      1:       return 5'b00010;
      0:       return 5'b00100;
      -1:      return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  // Root as an integer: value of the signed-digit string, wrapped to RT_W bits.
  function automatic logic [RT_W-1:0] ref_root(input dig_arr_t d, input bit neg);
    int v;
    v = 0;
    for (int i = 0; i < NUM_DIG; i++) v = v * 4 + d[i];
    if (neg) v = v - 1;
    return RT_W'(v);
  endfunction

  function automatic code_arr_t to_codes(input dig_arr_t d);
    code_arr_t c;
    for (int i = 0; i < NUM_DIG; i++) c[i] = enc(d[i]);
    return c;
  endfunction

  task automatic idle_inputs();
    bus.flush_i       = 1'b0;
    bus.start_valid_i = 1'b0;
    bus.dig_valid_i   = 1'b0;
    bus.rt_dig_i      = 5'b0;
    bus.rem_valid_i   = 1'b0;
    bus.rem_neg_i     = 1'b0;
    bus.rem_zero_i    = 1'b0;
    bus.res_ready_i   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start_valid_i = 1'b1;
    tick();
    bus.start_valid_i = 1'b0;
  endtask

  task automatic send_codes(input code_arr_t c, input bit gaps);
    for (int i = 0; i < NUM_DIG; i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          bus.rt_dig_i = 5'($urandom);
          tick();
        end
      end
      bus.dig_valid_i = 1'b1;
      bus.rt_dig_i    = c[i];
      tick();
      bus.dig_valid_i = 1'b0;
    end
  endtask

  task automatic send_rem(input bit neg, input bit zero);
    bus.rem_valid_i = 1'b1;
    bus.rem_neg_i   = neg;
    bus.rem_zero_i  = zero;
    tick();
    bus.rem_valid_i = 1'b0;
  endtask

  // Full operation; result sampled in the cycle after the remainder accept, then released after 'hold' stalled cycles.
  task automatic do_op(input code_arr_t c, input bit neg, input bit zero, input int hold, input bit gaps,
                       output logic vld, output logic [RT_W-1:0] rt, output logic inx);
    do_start();
    send_codes(c, gaps);
    send_rem(neg, zero);
    vld = bus.res_valid_o;
    rt  = bus.rt_o;
    inx = bus.inexact_o;
    for (int k = 0; k < hold; k++) begin
      bus.start_valid_i = $urandom_range(0, 1);
      bus.dig_valid_i   = $urandom_range(0, 1);
      bus.rem_valid_i   = $urandom_range(0, 1);
      tick();
    end
    bus.start_valid_i = 1'b0;
    bus.dig_valid_i   = 1'b0;
    bus.rem_valid_i   = 1'b0;
    bus.res_ready_i   = 1'b1;
    tick();
    bus.res_ready_i   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.start_ready_o !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", bus.start_ready_o); end
    checks++; if (bus.dig_ready_o !== 1'b0) begin errors++; $display("FAIL reset_dig_ready got=%b exp=0", bus.dig_ready_o); end
    checks++; if (bus.rem_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rem_ready got=%b exp=0", bus.rem_ready_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid_o); end
    checks++; if (bus.rt_o !== '0) begin errors++; $display("FAIL reset_rt got=%h exp=00", bus.rt_o); end
    checks++; if (bus.inexact_o !== 1'b0) begin errors++; $display("FAIL reset_inexact got=%b exp=0", bus.inexact_o); end
    checks++; if (bus.dig_err_o !== 1'b0) begin errors++; $display("FAIL reset_dig_err got=%b exp=0", bus.dig_err_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic vld, inx;
    logic [RT_W-1:0] rt;
    dig_arr_t d1 = '{2, -1, 0, 1};
    dig_arr_t d2 = '{1, 1, 1, 1};
    do_op(to_codes(d1), 1'b1, 1'b0, 0, 1'b0, vld, rt, inx);
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL t1_valid got=%b exp=1", vld); end
    checks++; if (rt !== 8'h70) begin errors++; $display("FAIL t1_rt got=%h exp=70", rt); end
    checks++; if (inx !== 1'b1) begin errors++; $display("FAIL t1_inexact got=%b exp=1", inx); end
    checks++; if (bus.res_valid_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin
      errors++; $display("FAIL t1_release got_vld=%b got_srdy=%b exp=0/1", bus.res_valid_o, bus.start_ready_o); end
    do_op(to_codes(d2), 1'b0, 1'b1, 0, 1'b0, vld, rt, inx);
    checks++; if (rt !== 8'h55) begin errors++; $display("FAIL t2_rt got=%h exp=55", rt); end
    checks++; if (inx !== 1'b0) begin errors++; $display("FAIL t2_inexact got=%b exp=0", inx); end
  endtask

  task automatic test_backpressure();
    dig_arr_t d1 = '{2, -1, 0, 1};
    do_start();
    send_codes(to_codes(d1), 1'b0);
    send_rem(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.start_valid_i = (k == 1);
      checks++; if (bus.res_valid_o !== 1'b1 || bus.rt_o !== 8'h71 || bus.inexact_o !== 1'b1) begin
        errors++; $display("FAIL t3_hold%0d got vld=%b rt=%h inx=%b exp 1/71/1", k, bus.res_valid_o, bus.rt_o, bus.inexact_o); end
      tick();
    end
    bus.start_valid_i = 1'b0;
    checks++; if (bus.res_valid_o !== 1'b1 || bus.start_ready_o !== 1'b0) begin
      errors++; $display("FAIL t3_start_ignored got vld=%b srdy=%b exp 1/0", bus.res_valid_o, bus.start_ready_o); end
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    checks++; if (bus.res_valid_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin
      errors++; $display("FAIL t3_release got vld=%b srdy=%b exp 0/1", bus.res_valid_o, bus.start_ready_o); end
  endtask

  task automatic test_flush();
    logic vld, inx;
    logic [RT_W-1:0] rt;
    dig_arr_t d = '{0, 0, 0, 2};
    do_start();
    bus.dig_valid_i = 1'b1; bus.rt_dig_i = enc(2);  tick();
    bus.rt_dig_i = enc(-2); tick();
    bus.rt_dig_i = enc(1);
    bus.flush_i  = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.dig_valid_i = 1'b0;
    checks++; if (bus.start_ready_o !== 1'b1 || bus.dig_ready_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle got srdy=%b drdy=%b vld=%b exp 1/0/0", bus.start_ready_o, bus.dig_ready_o, bus.res_valid_o); end
    bus.start_valid_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    bus.start_valid_i = 1'b0; bus.flush_i = 1'b0;
    checks++; if (bus.start_ready_o !== 1'b1 || bus.dig_ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_over_start got srdy=%b drdy=%b exp 1/0", bus.start_ready_o, bus.dig_ready_o); end
    do_op(to_codes(d), 1'b0, 1'b1, 1, 1'b0, vld, rt, inx);
    checks++; if (vld !== 1'b1 || rt !== 8'h02 || inx !== 1'b0) begin
      errors++; $display("FAIL flush_next_op got vld=%b rt=%h inx=%b exp 1/02/0", vld, rt, inx); end
  endtask

  task automatic test_async_reset();
    logic vld, inx;
    logic [RT_W-1:0] rt;
    dig_arr_t d = '{-2, 1, 2, -1};
    dig_arr_t d1 = '{2, 2, 2, 2};
    do_op(to_codes(d1), 1'b0, 1'b1, 0, 1'b0, vld, rt, inx);
    do_start();
    bus.dig_valid_i = 1'b1; bus.rt_dig_i = enc(1); tick(); tick();
    bus.dig_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rt_o !== '0 || bus.start_ready_o !== 1'b1 || bus.dig_ready_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
      errors++; $display("FAIL arst_clear got rt=%h srdy=%b drdy=%b vld=%b exp 00/1/0/0", bus.rt_o, bus.start_ready_o, bus.dig_ready_o, bus.res_valid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(to_codes(d), 1'b1, 1'b0, 0, 1'b0, vld, rt, inx);
    checks++; if (vld !== 1'b1 || rt !== ref_root(d, 1'b1) || inx !== 1'b1) begin
      errors++; $display("FAIL arst_next_op got vld=%b rt=%h inx=%b exp 1/%h/1", vld, rt, inx, ref_root(d, 1'b1)); end
  endtask

  task automatic test_onehot();
    logic vld, inx;
    logic [RT_W-1:0] rt;
    code_arr_t c = '{5'b00110, 5'b00010, 5'b00010, 5'b00010};
    dig_arr_t  d = '{0, 0, 0, 0};
    do_start();
    bus.dig_valid_i = 1'b1; bus.rt_dig_i = c[0]; tick();
    bus.dig_valid_i = 1'b0;
    checks++; if (bus.dig_err_o !== CHK_EN) begin errors++; $display("FAIL onehot_set got=%b exp=%b", bus.dig_err_o, CHK_EN); end
    for (int i = 1; i < NUM_DIG; i++) begin
      bus.dig_valid_i = 1'b1; bus.rt_dig_i = c[i]; tick();
    end
    bus.dig_valid_i = 1'b0;
    send_rem(1'b0, 1'b1);
    checks++; if (bus.rt_o !== 8'h15 || bus.dig_err_o !== CHK_EN) begin
      errors++; $display("FAIL onehot_hold got rt=%h err=%b exp 15/%b", bus.rt_o, bus.dig_err_o, CHK_EN); end
    bus.res_ready_i = 1'b1; tick(); bus.res_ready_i = 1'b0;
    do_op(to_codes(d), 1'b0, 1'b1, 0, 1'b0, vld, rt, inx);
    checks++; if (bus.dig_err_o !== 1'b0 || rt !== 8'h00) begin
      errors++; $display("FAIL onehot_clear got err=%b rt=%h exp 0/00", bus.dig_err_o, rt); end
  endtask

  task automatic test_random();
    logic vld, inx;
    logic [RT_W-1:0] rt;
    dig_arr_t d;
    bit neg, zero;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_DIG; i++) d[i] = int'($urandom_range(0, 4)) - 2;
      neg  = 1'($urandom_range(0, 1));
      zero = neg ? 1'b0 : 1'($urandom_range(0, 1));
      do_op(to_codes(d), neg, zero, int'($urandom_range(0, 3)), (n % 2) == 1, vld, rt, inx);
      checks++; if (vld !== 1'b1 || rt !== ref_root(d, neg) || inx !== (neg | ~zero)) begin
        errors++; $display("FAIL rand%0d got vld=%b rt=%h inx=%b exp 1/%h/%b", n, vld, rt, inx, ref_root(d, neg), neg | ~zero); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_onehot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
